// File: rtl/fp_to_int_converter.sv
// fp_to_int_converter
//   Multi-cycle IEEE-754 single-precision to signed 32-bit integer converter
//   (fcvt.w.s direction). The float is unpacked and its significand is
//   de-normalized by an iterative shifter that moves at most SHIFT_STEP bit
//   positions per cycle. The result is held until the next conversion ends.
//
//   Optional feature macro: FP2INT_ROUND_NEAREST_EN
//     undefined : round toward zero (guard/sticky bits ignored, e<0 -> 0)
//     defined   : round to nearest, ties to even (e==-1 shifts right by 24)
//
// Ports
//   clk      in   1   clock, all state changes on the rising edge
//   rst      in   1   synchronous active-high reset
//   Start    in   1   conversion request, sampled only while idle
//   Operand  in   32  IEEE-754 single, captured with an accepted Start
//   Busy     out  1   high from the cycle after an accepted Start until Done
//   Done     out  1   one-cycle pulse, Result/Invalid valid from this cycle on
//   Result   out  32  signed two's-complement result, held until next Done
//   Invalid  out  1   NaN, infinity or out-of-range input, held with Result

module fp_to_int_converter #(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [31:0] Operand,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Result,
  output logic        Invalid
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;
  localparam logic [4:0] STEP     = 5'(SHIFT_STEP);

  logic [1:0]  state_q,  state_d;
  logic [31:0] mag_q,    mag_d;
  logic        g_q,      g_d;
  logic        s_q,      s_d;
  logic [4:0]  cnt_q,    cnt_d;
  logic        left_q,   left_d;
  logic        sign_q,   sign_d;
  logic        inv_q,    inv_d;
  logic        busy_q,   busy_d;
  logic        done_q,   done_d;
  logic [31:0] result_q, result_d;
  logic        invalid_q, invalid_d;

  logic [7:0]        exp_field_s;
  logic [22:0]       frac_s;
  logic signed [9:0] e_s;
  logic [4:0]        amt_s;
  logic [31:0]       low_mask_s;
  logic              round_up_s;
  logic [31:0]       mag_rnd_s;

  // Unpack fields and derive the per-cycle shift amount and rounding decision.
  always_comb begin
    exp_field_s = Operand[30:23];
    frac_s      = Operand[22:0];
    e_s         = $signed({2'b00, exp_field_s}) - 10'sd127;
    amt_s       = (cnt_q > STEP) ? STEP : cnt_q;
    // Bits below the last bit shifted out feed the sticky bit.
    low_mask_s  = (32'd1 << (amt_s - 5'd1)) - 32'd1;
`ifdef FP2INT_ROUND_NEAREST_EN
    round_up_s  = g_q & (s_q | mag_q[0]);
`else
    round_up_s  = 1'b0;
`endif
    mag_rnd_s   = mag_q + {31'd0, round_up_s};
  end

  // Next-state and datapath logic for the IDLE -> SHIFT -> FINAL sequence.
  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    g_d       = g_q;
    s_d       = s_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    sign_d    = sign_q;
    inv_d     = inv_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    invalid_d = invalid_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          busy_d  = 1'b1;
          g_d     = 1'b0;
          s_d     = 1'b0;
          sign_d  = Operand[31];
          inv_d   = 1'b0;
          left_d  = 1'b0;
          cnt_d   = 5'd0;
          mag_d   = {8'd0, 1'b1, frac_s};
          state_d = ST_FINAL;
          if (exp_field_s == 8'd0) begin
            mag_d = 32'd0;
          end else if ((exp_field_s == 8'hFF) && (frac_s != 23'd0)) begin
            mag_d  = 32'h7FFF_FFFF;
            sign_d = 1'b0;
            inv_d  = 1'b1;
          end else if (e_s >= 10'sd31) begin
            // Saturation values are loaded as magnitudes; negating 2^31
            // in FINAL reproduces 0x80000000 unchanged.
            if (!Operand[31]) begin
              mag_d = 32'h7FFF_FFFF;
              inv_d = 1'b1;
            end else begin
              mag_d = 32'h8000_0000;
              inv_d = (e_s != 10'sd31) || (frac_s != 23'd0);
            end
          end else if (e_s >= 10'sd23) begin
            left_d = 1'b1;
            cnt_d  = 5'(e_s - 10'sd23);
            if (e_s != 10'sd23) begin
              state_d = ST_SHIFT;
            end else begin
              state_d = ST_FINAL;
            end
          end else if (e_s >= 10'sd0) begin
            cnt_d   = 5'(10'sd23 - e_s);
            state_d = ST_SHIFT;
`ifdef FP2INT_ROUND_NEAREST_EN
          end else if (e_s == -10'sd1) begin
            cnt_d   = 5'd24;
            state_d = ST_SHIFT;
`endif
          end else begin
            mag_d = 32'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (left_q) begin
          mag_d = mag_q << amt_s;
        end else begin
          mag_d = mag_q >> amt_s;
          g_d   = mag_q[amt_s - 5'd1];
          // The previous guard bit is now below the new one: fold it into sticky.
          s_d   = s_q | g_q | (|(mag_q & low_mask_s));
        end
        cnt_d = cnt_q - amt_s;
        if (cnt_q == amt_s) begin
          state_d = ST_FINAL;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_FINAL: begin
        result_d  = sign_q ? (32'd0 - mag_rnd_s) : mag_rnd_s;
        invalid_d = inv_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mag_q     <= 32'd0;
      g_q       <= 1'b0;
      s_q       <= 1'b0;
      cnt_q     <= 5'd0;
      left_q    <= 1'b0;
      sign_q    <= 1'b0;
      inv_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 32'd0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      g_q       <= g_d;
      s_q       <= s_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
      sign_q    <= sign_d;
      inv_q     <= inv_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      invalid_q <= invalid_d;
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Result  = result_q;
  assign Invalid = invalid_q;

endmodule

// File: tb/tb_fp_to_int_converter.sv
module tb_fp_to_int_converter;

  logic        clk;
  logic        rst;
  logic        Start;
  logic [31:0] Operand;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;
  logic        Invalid;

  int tests;
  int fails;

  fp_to_int_converter #(.SHIFT_STEP(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .Start   (Start),
    .Operand (Operand),
    .Busy    (Busy),
    .Done    (Done),
    .Result  (Result),
    .Invalid (Invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op;
    logic [31:0] res;
    logic        inv;
    int          k;
    string       name;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: exact value of the float, rounded by integer division, then range-checked.
  function automatic void model(input logic [31:0] op, output logic [31:0] res,
                                output logic inv, output int k);
    int     exp_f;
    int     e;
    int     sh;
    longint frac;
    longint sig;
    longint q;
    longint rem;
    longint half;
    longint mag;
    longint v;
    bit     rne;
`ifdef FP2INT_ROUND_NEAREST_EN
    rne = 1'b1;
`else
    rne = 1'b0;
`endif
    k     = 0;
    exp_f = int'(op[30:23]);
    frac  = longint'(op[22:0]);
    sig   = frac + 64'sd8388608;
    e     = exp_f - 127;
    if (exp_f == 255 && frac != 0) begin
      res = 32'h7FFF_FFFF;
      inv = 1'b1;
      return;
    end
    if (exp_f == 0) begin
      mag = 0;
    end else if (exp_f == 255 || e > 40) begin
      mag = 64'sd1 << 41;
    end else if (e >= 23) begin
      mag = sig << (e - 23);
      if (e < 31) k = (e - 23 + 3) / 4;
    end else if (e >= 0 || (rne && e == -1)) begin
      sh   = 23 - e;
      q    = sig >> sh;
      rem  = sig - (q << sh);
      half = 64'sd1 << (sh - 1);
      if (rne && (rem > half || (rem == half && (q & 64'sd1) != 0))) q = q + 1;
      mag = q;
      k   = (sh + 3) / 4;
    end else begin
      mag = 0;
    end
    v = op[31] ? -mag : mag;
    if (v > 64'sd2147483647) begin
      res = 32'h7FFF_FFFF;
      inv = 1'b1;
    end else if (v < -64'sd2147483648) begin
      res = 32'h8000_0000;
      inv = 1'b1;
    end else begin
      res = v[31:0];
      inv = 1'b0;
    end
  endfunction

  // Issue one conversion and check latency, Busy profile, Result and Invalid.
  // poke_at > 0 raises Start with poke_op at that sample while the unit is busy.
  task automatic run_op(input logic [31:0] op, input logic [31:0] exp_res, input logic exp_inv,
                        input int exp_k, input string name, input int poke_at,
                        input logic [31:0] poke_op);
    int done_idx;
    int busy_bad;
    Operand = op;
    Start   = 1'b1;
    @(posedge clk);
    #1;
    Start    = 1'b0;
    done_idx = 0;
    busy_bad = 0;
    for (int j = 1; j <= 40 && done_idx == 0; j++) begin
      @(negedge clk);
      if (Busy !== ((j <= exp_k + 1) ? 1'b1 : 1'b0)) busy_bad++;
      if (Done === 1'b1) done_idx = j;
      if (j == poke_at) begin
        Operand = poke_op;
        Start   = 1'b1;
      end else begin
        Start = 1'b0;
      end
    end
    Start = 1'b0;
    check({name, " latency"}, 32'(done_idx), 32'(exp_k + 2));
    check({name, " busy"}, 32'(busy_bad), 32'd0);
    check({name, " result"}, Result, exp_res);
    check({name, " invalid"}, {31'd0, Invalid}, {31'd0, exp_inv});
  endtask

  initial begin
    logic [31:0] op;
    logic [31:0] r;
    logic [31:0] m_res;
    logic        m_inv;
    int          m_k;
    int          done_cnt;

    tests   = 0;
    fails   = 0;
    rst     = 1'b1;
    Start   = 1'b0;
    Operand = 32'd0;

    vecs[0]  = '{32'h3F80_0000, 32'h0000_0001, 1'b0, 6, "one"};
    vecs[1]  = '{32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 6, "neg2p5"};
`ifdef FP2INT_ROUND_NEAREST_EN
    vecs[2]  = '{32'h4060_0000, 32'h0000_0004, 1'b0, 6, "3p5"};
    vecs[3]  = '{32'h3F40_0000, 32'h0000_0001, 1'b0, 6, "0p75"};
`else
    vecs[2]  = '{32'h4060_0000, 32'h0000_0003, 1'b0, 6, "3p5"};
    vecs[3]  = '{32'h3F40_0000, 32'h0000_0000, 1'b0, 0, "0p75"};
`endif
    vecs[4]  = '{32'h4E80_0000, 32'h4000_0000, 1'b0, 2, "2pow30"};
    vecs[5]  = '{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 0, "2pow31"};
    vecs[6]  = '{32'hCF00_0000, 32'h8000_0000, 1'b0, 0, "neg2pow31"};
    vecs[7]  = '{32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 0, "nan"};
    vecs[8]  = '{32'hFF80_0000, 32'h8000_0000, 1'b1, 0, "neginf"};
    vecs[9]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 0, "zero"};
    vecs[10] = '{32'h8000_0000, 32'h0000_0000, 1'b0, 0, "negzero"};
    vecs[11] = '{32'h0000_0001, 32'h0000_0000, 1'b0, 0, "denormal"};
    vecs[12] = '{32'h4B00_0000, 32'h0080_0000, 1'b0, 0, "2pow23"};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", {31'd0, Busy}, 32'd0);
    check("reset done", {31'd0, Done}, 32'd0);
    check("reset result", Result, 32'd0);
    check("reset invalid", {31'd0, Invalid}, 32'd0);

    // Directed vectors, issued back-to-back (each Start lands in the previous Done cycle).
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].op, vecs[i].res, vecs[i].inv, vecs[i].k, vecs[i].name, 0, 32'd0);
    end

    // Start pulsed while busy is ignored; the first result stands.
    run_op(32'h3F80_0000, 32'h0000_0001, 1'b0, 6, "ignore_start", 2, 32'h7FC0_0000);
    @(negedge clk);
    check("ignore_start no restart", {31'd0, Busy}, 32'd0);

    // Reset in the middle of SHIFT aborts the operation silently.
    run_op(32'h4060_0000, vecs[2].res, 1'b0, 6, "pre_reset", 0, 32'd0);
    Operand = 32'h3F80_0000;
    Start   = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midreset busy", {31'd0, Busy}, 32'd0);
    check("midreset done", {31'd0, Done}, 32'd0);
    check("midreset result", Result, 32'd0);
    done_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (Done === 1'b1) done_cnt++;
    end
    check("midreset no done", 32'(done_cnt), 32'd0);

    // Randomized operands against the reference model.
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      if ((i % 3) != 0) begin
        op = {r[31], 8'($urandom_range(115, 160)), r[22:0]};
      end else begin
        op = r;
      end
      if ((i % 4) == 1) op[12:0] = 13'd0;
      model(op, m_res, m_inv, m_k);
      run_op(op, m_res, m_inv, m_k, $sformatf("rand%0d op=%h", i, op), 0, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
